// File: rtl/vga_fb_fetch_arbiter.sv
// Framebuffer row prefetcher with ping-pong line buffer feeding the VGA pixstream; spare RAM
// cycles go to a renderer write port. Optional macro WRITER_SLOT_EN opens a writer slot every 4th fetch cycle.
module vga_fb_fetch_arbiter #(
    parameter int FB_W   = 320,
    parameter int FB_H   = 240,
    parameter int SCALE  = 2,
    parameter int VRES   = 480,
    parameter int VTOTAL = 525,
    parameter int ADDR_W = 17
) (
    input  logic              clk_25_175,
    input  logic              reset,
    input  logic [9:0]        hpos,
    input  logic [9:0]        vpos,
    output logic [11:0]       pix_out,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [11:0]       mem_wdata,
    input  logic [11:0]       mem_rdata,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [11:0]       wr_data,
    output logic              wr_ready,
    output logic              busy,
    output logic              fetch_overrun
);
    localparam int XW = (FB_W > 1) ? $clog2(FB_W) : 1;
    localparam int SS = $clog2(SCALE);
    localparam logic [XW-1:0]     X_LAST  = XW'(FB_W - 1);
    localparam logic [9:0]        FB_W_C  = 10'(FB_W);
    localparam logic [9:0]        FB_H_C  = 10'(FB_H);
    localparam logic [9:0]        VRES_C  = 10'(VRES);
    localparam logic [9:0]        VLAST_C = 10'(VTOTAL - 1);
    localparam logic [9:0]        SMASK   = 10'(SCALE - 1);
    localparam logic [ADDR_W-1:0] FB_W_A  = ADDR_W'(FB_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [9:0]        vpos_d;
    logic [9:0]        vrow, next_row, col;
    logic              trig;
    logic [9:0]        trig_row;
    logic [XW-1:0]     x, x_d;
    logic [ADDR_W-1:0] base;
    logic              bank;
    logic              rd_pend;
    logic              run;
    logic              slot;
    logic              rd_issue;
    logic [11:0]       lbuf [0:1][0:FB_W-1];

    assign vrow     = vpos >> SS;
    assign next_row = vrow + 10'd1;
    assign col      = hpos >> SS;

    // A line change either starts the next row fetch or, on the last frame line, row 0.
    always_comb begin
        trig     = 1'b0;
        trig_row = '0;
        if (vpos != vpos_d) begin
            if (vpos == VLAST_C) begin
                trig = 1'b1;
            end else if (vpos < VRES_C && (vpos & SMASK) == 10'd0 && next_row < FB_H_C) begin
                trig     = 1'b1;
                trig_row = next_row;
            end
        end
    end

`ifdef WRITER_SLOT_EN
    logic [1:0] phase;

    always_ff @(posedge clk_25_175 or negedge reset) begin
        if (!reset)
            phase <= '0;
        else if (state != FETCH)
            phase <= '0;
        else
            phase <= phase + 2'd1;
    end

    assign slot = (state == FETCH) && (phase == 2'd0);
`else
    assign slot = 1'b0;
`endif

    assign rd_issue  = (state == FETCH) && !slot;
    // run keeps the write port closed while reset is applied
    assign wr_ready  = run && (((state == IDLE) && !trig) || slot);
    assign mem_we    = wr_valid && wr_ready;
    assign mem_re    = rd_issue;
    assign mem_addr  = rd_issue ? base + ADDR_W'(x) : (mem_we ? wr_addr : '0);
    assign mem_wdata = mem_we ? wr_data : 12'd0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk_25_175 or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (trig) state_next = FETCH;
            FETCH:   if (rd_issue && x == X_LAST) state_next = DRAIN;
            DRAIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_25_175 or negedge reset) begin
        if (!reset) begin
            vpos_d        <= '0;
            run           <= 1'b0;
            fetch_overrun <= 1'b0;
            x             <= '0;
            x_d           <= '0;
            base          <= '0;
            bank          <= 1'b0;
            rd_pend       <= 1'b0;
            pix_out       <= '0;
        end else begin
            vpos_d  <= vpos;
            run     <= 1'b1;
            rd_pend <= rd_issue;
            x_d     <= x;
            if (trig && state != IDLE)
                fetch_overrun <= 1'b1;
            if (state == IDLE && trig) begin
                x    <= '0;
                base <= ADDR_W'(trig_row) * FB_W_A;
                bank <= trig_row[0];
            end else if (rd_issue) begin
                x <= (x == X_LAST) ? '0 : x + 1'b1;
            end
            if (vpos < VRES_C && col < FB_W_C)
                pix_out <= lbuf[vrow[0]][col[XW-1:0]];
            else
                pix_out <= '0;
        end
    end

    // Read data lands one cycle after issue, so the write uses the delayed column.
    always_ff @(posedge clk_25_175) begin
        if (rd_pend)
            lbuf[bank][x_d] <= mem_rdata;
    end

endmodule

// File: tb/tb_vga_fb_fetch_arbiter.sv
// Bench for vga_fb_fetch_arbiter: RAM model, transaction-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_vga_fb_fetch_arbiter;
    localparam int FB_W   = 320;
    localparam int FB_H   = 240;
    localparam int SCALE  = 2;
    localparam int VRES   = 480;
    localparam int VTOTAL = 525;
    localparam int ADDR_W = 17;
`ifdef WRITER_SLOT_EN
    localparam bit SLOT = 1'b1;
`else
    localparam bit SLOT = 1'b0;
`endif
    localparam int FLEN = SLOT ? FB_W + (FB_W + 2) / 3 + 1 : FB_W + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [9:0]        hpos = '0;
    logic [9:0]        vpos = '0;
    logic [11:0]       pix_out;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re, mem_we;
    logic [11:0]       mem_wdata;
    logic [11:0]       mem_rdata = '0;
    logic              wr_valid = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [11:0]       wr_data = '0;
    logic              wr_ready, busy, fetch_overrun;

    always #5 clk = ~clk;

    vga_fb_fetch_arbiter #(
        .FB_W(FB_W), .FB_H(FB_H), .SCALE(SCALE), .VRES(VRES), .VTOTAL(VTOTAL), .ADDR_W(ADDR_W)
    ) dut (
        .clk_25_175(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .pix_out(pix_out),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .busy(busy), .fetch_overrun(fetch_overrun)
    );

    // registered-read single-port RAM
    logic [11:0] ram [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= ram[mem_addr];
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int row_for(int v, int vp);
        if (v == vp) return -1;
        if (v == VTOTAL - 1) return 0;
        if (v < VRES && v % SCALE == 0 && v / SCALE + 1 < FB_H) return v / SCALE + 1;
        return -1;
    endfunction

    function automatic int read_idx(int k);
        if (k < 1 || k > FLEN - 1) return -1;
        if (!SLOT) return k - 1;
        if ((k - 1) % 4 == 0) return -1;
        return k - 1 - ((k - 1) / 4 + 1);
    endfunction

    function automatic bit slot_cycle(int k);
        return SLOT && k >= 1 && k <= FLEN - 1 && (k - 1) % 4 == 0;
    endfunction

    int          m_k = 0;       // cycles since fetch start; 0 means idle
    int          m_base = 0;
    int          m_bank = 0;
    int          m_vprev = 0;
    bit          m_run = 0;
    bit          m_over = 0;
    bit          m_valid [2] = '{0, 0};
    logic [11:0] m_buf [2][FB_W];
    logic [11:0] m_row [FB_W];
    logic [11:0] m_pix = '0;
    bit          m_known = 1;

    initial forever begin
        int tr, c;
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_k = 0; m_vprev = 0; m_run = 0; m_over = 0;
            m_valid[0] = 0; m_valid[1] = 0;
            m_pix = '0; m_known = 1;
        end else begin
            tr = row_for(int'(vpos), m_vprev);
            c  = int'(hpos) / SCALE;
            if (vpos >= VRES || c >= FB_W) begin
                m_pix = '0; m_known = 1;
            end else if (m_valid[(int'(vpos) / SCALE) % 2]) begin
                m_pix = m_buf[(int'(vpos) / SCALE) % 2][c]; m_known = 1;
            end else begin
                m_known = 0;
            end
            if (m_k != 0) begin
                if (tr >= 0) m_over = 1;
                if (m_k == FLEN) begin
                    for (int i = 0; i < FB_W; i++) m_buf[m_bank][i] = m_row[i];
                    m_valid[m_bank] = 1;
                    m_k = 0;
                end else begin
                    m_k++;
                end
            end else if (tr >= 0) begin
                m_k = 1;
                m_base = tr * FB_W;
                m_bank = tr % 2;
                m_valid[m_bank] = 0;
                for (int i = 0; i < FB_W; i++) m_row[i] = ram[m_base + i];
            end
            m_vprev = int'(vpos);
            m_run = 1;
        end
    end

    // per-cycle compare against the model
    initial forever begin
        int ri;
        bit exp_ready, exp_we;
        @(negedge clk);
        ri        = read_idx(m_k);
        exp_ready = m_run && ((m_k == 0 && row_for(int'(vpos), m_vprev) < 0) || slot_cycle(m_k));
        exp_we    = wr_valid && exp_ready;
        check("busy", busy, m_k != 0);
        check("mem_re", mem_re, ri >= 0);
        if (ri >= 0) check("rd_addr", mem_addr, m_base + ri);
        check("wr_ready", wr_ready, exp_ready);
        check("mem_we", mem_we, exp_we);
        if (exp_we) begin
            check("wr_addr_out", mem_addr, wr_addr);
            check("wr_data_out", mem_wdata, wr_data);
        end
        check("re_we_excl", mem_re & mem_we, 1'b0);
        check("overrun", fetch_overrun, m_over);
        if (m_known) check("pix_out", pix_out, m_pix);
    end

    // ---------------- stimulus ----------------
    bit         hpos_free = 1;
    logic [9:0] hpos_force = '0;
    initial forever begin
        @(posedge clk);
        #2;
        if (hpos_free) hpos = (hpos == 10'd799) ? 10'd0 : hpos + 10'd1;
        else hpos = hpos_force;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_fetch(output int len, output int first, output int last);
        len = 0; first = -1; last = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (busy) begin
                len++;
                if (mem_re) begin
                    if (first < 0) first = int'(mem_addr);
                    last = int'(mem_addr);
                end
            end else if (len > 0) begin
                break;
            end
        end
        tick(1);
    endtask

    initial begin
        int len, first, last, stall, got, acc;
        for (int k = 0; k < (1 << ADDR_W); k++) ram[k] = 12'(k);

        @(negedge clk);
        check("rst_pix", pix_out, 12'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_re", mem_re, 1'b0);
        check("rst_ready", wr_ready, 1'b0);
        check("rst_ovr", fetch_overrun, 1'b0);
        tick(1);
        reset = 1'b1;
        tick(2);
        check("idle_busy", busy, 1'b0);
        check("idle_ready", wr_ready, 1'b1);

        // row 0 fetch at the last frame line
        vpos = 10'd524;
        run_fetch(len, first, last);
        check("row0_len", len, FLEN);
        check("row0_first", first, 0);
        check("row0_last", last, FB_W - 1);

        hpos_free = 0; hpos_force = 10'd10;
        vpos = 10'd0;
        #2;
        @(posedge clk);
        @(negedge clk);
        check("pix_r0_c5", pix_out, 12'd5);
        hpos_free = 1;
        run_fetch(len, first, last);

        vpos = 10'd1;
        tick(3);
        check("odd_no_fetch", busy, 1'b0);
        vpos = 10'd2;
        run_fetch(len, first, last);
        check("row2_len", len, FLEN);
        check("row2_first", first, 640);
        check("row2_last", last, 959);

        vpos = 10'd3;
        tick(2);
`ifdef WRITER_SLOT_EN
        vpos = 10'd4;
        wr_valid = 1'b1; wr_addr = 17'd50000; wr_data = 12'h5A5;
        len = 0; acc = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (busy) begin
                len++;
                if (mem_we) acc++;
            end else if (len > 0) begin
                break;
            end
        end
        check("slot_len", len, FLEN);
        check("slot_acc", acc, (FB_W + 2) / 3);
        tick(1);
        wr_valid = 1'b0;
        check("slot_ram", ram[50000], 12'h5A5);
`else
        vpos = 10'd4;
        tick(1);
        wr_valid = 1'b1; wr_addr = 17'd967; wr_data = 12'hABC;
        stall = 0; got = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (wr_ready) begin
                got = 1;
                break;
            end
            stall++;
        end
        check("wr_stall", stall, FB_W + 1);
        check("wr_accept", got, 1);
        check("wr_we", mem_we, 1'b1);
        check("wr_addr", mem_addr, 17'd967);
        tick(1);
        wr_valid = 1'b0;
        check("ram_written", ram[967], 12'hABC);
`endif

        // trigger while busy
        vpos = 10'd6;
        tick(51);
        check("ovr_before", fetch_overrun, 1'b0);
        vpos = 10'd8;
        tick(1);
        check("ovr_set", fetch_overrun, 1'b1);
        run_fetch(len, first, last);
        check("ovr_last_addr", last, 5 * FB_W - 1);
        tick(5);
        check("ovr_sticky", fetch_overrun, 1'b1);
        check("ovr_idle", busy, 1'b0);

        // reset in the middle of a fetch (x = 100)
        vpos = 10'd10;
        tick(101);
        reset = 1'b0;
        #1;
        check("mid_rst_pix", pix_out, 12'd0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_re", mem_re, 1'b0);
        check("mid_rst_we", mem_we, 1'b0);
        check("mid_rst_ready", wr_ready, 1'b0);
        check("mid_rst_ovr", fetch_overrun, 1'b0);
        check("mid_rst_addr", mem_addr, 17'd0);
        vpos = 10'd0;
        tick(3);
        reset = 1'b1;
        tick(2);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_ready", wr_ready, 1'b1);
        tick(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_fb_fetch_arbiter.md
Name: vga_fb_fetch_arbiter

Overview:
- Sits between a single-port 12-bit framebuffer RAM and the VGA timing core.
- Prefetches one source row per SCALE display lines into an internal ping-pong line buffer.
- Feeds the core's pixstream from that buffer, using the core's registered hscan/vscan position.
- Arbitrates leftover RAM bandwidth to a renderer write port via a valid/ready handshake.

Parameters:
- FB_W, 320, framebuffer width in pixels (one 12-bit word per pixel)
- FB_H, 240, framebuffer height
- SCALE, 2, display pixels/lines per framebuffer pixel/row (power of 2)
- VRES, 480, visible display lines
- VTOTAL, 525, total display lines per frame
- ADDR_W, 17, RAM address width (FB_W*FB_H must be ≤ 2^ADDR_W)

Ports:
- clk_25_175  in  1  pixel clock
- reset  in  1  asynchronous active-low reset
- hpos  in  10  current horizontal position from VGA core
- vpos  in  10  current vertical position from VGA core
- pix_out  out  12  pixel to core pixstream, {b,g,r}
- mem_addr  out  ADDR_W  RAM address
- mem_re  out  1  RAM read strobe; data valid on mem_rdata one cycle later
- mem_we  out  1  RAM write strobe
- mem_wdata  out  12  RAM write data
- mem_rdata  in  12  RAM read data
- wr_valid  in  1  renderer write request
- wr_addr  in  ADDR_W  renderer write address
- wr_data  in  12  renderer write data
- wr_ready  out  1  write accepted this cycle when wr_valid & wr_ready
- busy  out  1  fetch in progress
- fetch_overrun  out  1  sticky: a fetch trigger arrived while busy

Behaviour:
- Reset (async, reset==0): all outputs 0, FSM=IDLE, counters 0, vpos_d=0, line-buffer contents undefined.
- Trigger detection: vpos_d registered each cycle; event when vpos != vpos_d.
  - vpos < VRES and vpos%SCALE==0 and (vpos/SCALE)+1 < FB_H: fetch row (vpos/SCALE)+1 into bank ((vpos/SCALE)+1)[0].
  - vpos == VTOTAL-1: fetch row 0 into bank 0.
  - Otherwise: no fetch.
- Display read: pix_out <= bank[(vpos/SCALE)[0]][hpos/SCALE]; 1-cycle latency.
  - Outside visible area (hpos/SCALE ≥ FB_W or vpos ≥ VRES): pix_out <= 0.
- FSM:
  - IDLE: on trigger, load row, x=0, base=row*FB_W, busy=1 -> FETCH.
  - FETCH: each cycle mem_re=1, mem_addr=base+x, x++.
    - After issuing x==FB_W-1 -> DRAIN.
    - Returned data is written to bank[x_d] one cycle after issue.
  - DRAIN: capture the final word; busy=0 the following cycle -> IDLE.
  - A fetch takes exactly FB_W+1 cycles from trigger to busy falling; 321 < 800 line clocks.
- Trigger while busy: fetch_overrun<=1 (cleared only by reset); trigger ignored, current fetch completes.
- Arbitration:
  - wr_ready = (state==IDLE) & no trigger this cycle; fetch has absolute priority.
  - On wr_valid&wr_ready: mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data, same cycle (combinational mux, registered-address RAM).
  - mem_re and mem_we are never both 1.
  - Renderer must hold wr_valid/wr_addr/wr_data stable until accepted.
- Arithmetic: row*FB_W computed once at trigger into an ADDR_W register; x is ceil(log2(FB_W)) bits and never exceeds FB_W-1.

Optional Feature:
- WRITER_SLOT_EN defined: during FETCH, every 4th cycle (x counter phase tracked separately) issues no read and grants wr_ready.
  - Fetch then takes FB_W + FB_W/3 (rounded up) + 1 cycles.
  - Bound: FB_W*4/3 + 1 must stay below HTOTAL.
- WRITER_SLOT_EN not defined: writer is fully stalled during FETCH.

Test Plan:
- Reset mid-FETCH (x=100): all outputs 0 immediately; after release, busy=0 and wr_ready=1 in IDLE.
- vpos 524->0 (fetch row 0 at 524), RAM word k = k: after fetch, hpos=10 on vpos=0 gives pix_out=5 next cycle.
- vpos 0->1 (odd, SCALE=2): no fetch. vpos 1->2: fetch of row 2 issues mem_addr 640..959, busy high exactly 321 cycles.
- wr_valid held during fetch: wr_ready=0 for 321 cycles, then accepted; mem_we=1 with given addr/data, never overlapping mem_re.
- Force vpos change while busy: fetch_overrun=1 and stays 1; the running fetch finishes with correct addresses.
- WRITER_SLOT_EN, wr_valid held high throughout: one write accepted every 4th FETCH cycle; buffered line still matches RAM.
